perf_csr_ctrl: RTL and testbench

PERF_CSR_CTRL -- requirements
Module: perf_csr_ctrl

---
 rtl/perf_csr_ctrl.sv | 168 ++++++++++++++++
 tb/tb_perf_csr_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_csr_ctrl.sv
// perf_csr_ctrl: 64-bit cycle / retired-instruction counters with a simple
// request/response CSR port (one access per two cycles), an mcountinhibit
// register, and per-counter high-half snapshot shadows so that a low-half read
// followed by a high-half read returns a coherent 64-bit value.
module perf_csr_ctrl #(
    parameter logic [2:0] INHIBIT_RST = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instret_en,
    input  logic        csr_req,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        csr_ready,
    output logic [31:0] csr_rdata,
    output logic        csr_err,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
);

    localparam logic [11:0] ADDR_CYCLE_LO   = 12'hB00;
    localparam logic [11:0] ADDR_CYCLE_HI   = 12'hB80;
    localparam logic [11:0] ADDR_INSTRET_LO = 12'hB02;
    localparam logic [11:0] ADDR_INSTRET_HI = 12'hB82;
    localparam logic [11:0] ADDR_INHIBIT    = 12'h320;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic        inh_cy_q, inh_cy_d;
    logic        inh_ir_q, inh_ir_d;
    logic [31:0] shadow_cy_q, shadow_cy_d;
    logic        shadow_cy_vld_q, shadow_cy_vld_d;
    logic [31:0] shadow_ir_q, shadow_ir_d;
    logic        shadow_ir_vld_q, shadow_ir_vld_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic accept;
    logic acc_wr;
    logic acc_rd;
    logic sel_cyc_lo, sel_cyc_hi, sel_ir_lo, sel_ir_hi, sel_inh, sel_mapped;
    logic cycle_wr, instret_wr;
    logic resp_valid;

    // A request is only taken while idle; requests during RESP are dropped.
    assign accept     = (state_q == IDLE) && csr_req;
    assign acc_wr     = accept && csr_we;
    assign acc_rd     = accept && !csr_we;

    assign sel_cyc_lo = (csr_addr == ADDR_CYCLE_LO);
    assign sel_cyc_hi = (csr_addr == ADDR_CYCLE_HI);
    assign sel_ir_lo  = (csr_addr == ADDR_INSTRET_LO);
    assign sel_ir_hi  = (csr_addr == ADDR_INSTRET_HI);
    assign sel_inh    = (csr_addr == ADDR_INHIBIT);
    assign sel_mapped = sel_cyc_lo | sel_cyc_hi | sel_ir_lo | sel_ir_hi | sel_inh;

    assign cycle_wr   = acc_wr && (sel_cyc_lo || sel_cyc_hi);
    assign instret_wr = acc_wr && (sel_ir_lo || sel_ir_hi);

    // State register and all datapath flops; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cycle_q         <= '0;
            instret_q       <= '0;
            inh_cy_q        <= INHIBIT_RST[0];
            inh_ir_q        <= INHIBIT_RST[2];
            shadow_cy_q     <= '0;
            shadow_cy_vld_q <= 1'b0;
            shadow_ir_q     <= '0;
            shadow_ir_vld_q <= 1'b0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cycle_q         <= cycle_d;
            instret_q       <= instret_d;
            inh_cy_q        <= inh_cy_d;
            inh_ir_q        <= inh_ir_d;
            shadow_cy_q     <= shadow_cy_d;
            shadow_cy_vld_q <= shadow_cy_vld_d;
            shadow_ir_q     <= shadow_ir_d;
            shadow_ir_vld_q <= shadow_ir_vld_d;
            rdata_q         <= rdata_d;
            err_q           <= err_d;
        end
    end

    // Next-state: every accepted access spends exactly one cycle in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csr_req) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response outputs; gated by rst so a pending response is dropped.
    always_comb begin
        resp_valid = (state_q == RESP) && !rst;
        csr_ready  = resp_valid;
        csr_rdata  = resp_valid ? rdata_q : 32'h0;
        csr_err    = resp_valid ? err_q : 1'b0;
    end

    // Counter increment/write, inhibit update, shadow capture and read mux.
    always_comb begin
        // Increments use the pre-write inhibit; a write to a counter freezes it.
        cycle_d         = (inh_cy_q || cycle_wr) ? cycle_q : cycle_q + 64'd1;
        instret_d       = (inh_ir_q || instret_wr || !instret_en) ? instret_q
                                                                  : instret_q + 64'd1;
        inh_cy_d        = inh_cy_q;
        inh_ir_d        = inh_ir_q;
        shadow_cy_d     = shadow_cy_q;
        shadow_cy_vld_d = shadow_cy_vld_q;
        shadow_ir_d     = shadow_ir_q;
        shadow_ir_vld_d = shadow_ir_vld_q;
        rdata_d         = 32'h0;
        err_d           = accept && !sel_mapped;

        if (acc_wr) begin
            if (sel_cyc_lo) cycle_d   = {cycle_q[63:32], csr_wdata};
            if (sel_cyc_hi) cycle_d   = {csr_wdata, cycle_q[31:0]};
            if (sel_ir_lo)  instret_d = {instret_q[63:32], csr_wdata};
            if (sel_ir_hi)  instret_d = {csr_wdata, instret_q[31:0]};
            if (sel_inh) begin
                inh_cy_d = csr_wdata[0];
                inh_ir_d = csr_wdata[2];
            end
            if (cycle_wr)   shadow_cy_vld_d = 1'b0;
            if (instret_wr) shadow_ir_vld_d = 1'b0;
        end

        if (acc_rd) begin
            if (sel_cyc_lo) begin
                rdata_d         = cycle_q[31:0];
                shadow_cy_d     = cycle_q[63:32];
                shadow_cy_vld_d = 1'b1;
            end
            if (sel_cyc_hi) begin
                rdata_d         = shadow_cy_vld_q ? shadow_cy_q : cycle_q[63:32];
                shadow_cy_vld_d = 1'b0;
            end
            if (sel_ir_lo) begin
                rdata_d         = instret_q[31:0];
                shadow_ir_d     = instret_q[63:32];
                shadow_ir_vld_d = 1'b1;
            end
            if (sel_ir_hi) begin
                rdata_d         = shadow_ir_vld_q ? shadow_ir_q : instret_q[63:32];
                shadow_ir_vld_d = 1'b0;
            end
            if (sel_inh) rdata_d = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_perf_csr_ctrl.sv
// Testbench for perf_csr_ctrl: a transaction-level model advanced by the
// driver pushes expected responses into a queue; a negedge monitor pops them
// whenever the DUT raises csr_ready.
module tb_perf_csr_ctrl;

    localparam logic [2:0] INH_RST = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        instret_en;
    logic        csr_req;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ready;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic [63:0] cycle_count;
    logic [63:0] instret_count;

    always #5 clk = ~clk;

    perf_csr_ctrl #(.INHIBIT_RST(INH_RST)) dut (
        .clk          (clk),
        .rst          (rst),
        .instret_en   (instret_en),
        .csr_req      (csr_req),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_ready    (csr_ready),
        .csr_rdata    (csr_rdata),
        .csr_err      (csr_err),
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model state (advanced once per driven cycle)
    bit          m_busy;
    logic [63:0] m_cycle, m_instret;
    bit          m_cy, m_ir;
    logic [31:0] m_sh_cy, m_sh_ir;
    bit          m_sh_cy_v, m_sh_ir_v;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: sample outputs mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (csr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", {63'b0, csr_ready}, 64'd0);
            end else begin
                $display("resp rdata=%h err=%b (exp rdata=%h err=%b)",
                         csr_rdata, csr_err, exp_q[0].rdata, exp_q[0].err);
                check_eq("resp_rdata", {32'b0, csr_rdata}, {32'b0, exp_q[0].rdata});
                check_eq("resp_err", {63'b0, csr_err}, {63'b0, exp_q[0].err});
                void'(exp_q.pop_front());
            end
        end else begin
            check_eq("idle_outputs", {31'b0, csr_err, csr_rdata}, 64'd0);
        end
    end

    task automatic model_reset();
        m_busy    = 1'b0;
        m_cycle   = '0;
        m_instret = '0;
        m_cy      = INH_RST[0];
        m_ir      = INH_RST[2];
        m_sh_cy   = '0;
        m_sh_ir   = '0;
        m_sh_cy_v = 1'b0;
        m_sh_ir_v = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus (inputs change 1 time unit after the edge)
    task automatic cyc(input bit req, input bit we, input logic [11:0] addr,
                       input logic [31:0] wd, input bit ie);
        bit          acc;
        logic [63:0] nc, ni;
        resp_t       r;
        rst        = 1'b0;
        csr_req    = req;
        csr_we     = we;
        csr_addr   = addr;
        csr_wdata  = wd;
        instret_en = ie;
        acc = !m_busy && req;
        nc  = m_cy ? m_cycle : m_cycle + 64'd1;
        ni  = (ie && !m_ir) ? m_instret + 64'd1 : m_instret;
        r   = '0;
        if (acc) begin
            if (we) begin
                case (addr)
                    12'hB00: begin nc = {m_cycle[63:32], wd};   m_sh_cy_v = 1'b0; end
                    12'hB80: begin nc = {wd, m_cycle[31:0]};    m_sh_cy_v = 1'b0; end
                    12'hB02: begin ni = {m_instret[63:32], wd}; m_sh_ir_v = 1'b0; end
                    12'hB82: begin ni = {wd, m_instret[31:0]};  m_sh_ir_v = 1'b0; end
                    12'h320: begin m_cy = wd[0]; m_ir = wd[2]; end
                    default: r.err = 1'b1;
                endcase
            end else begin
                case (addr)
                    12'hB00: begin r.rdata = m_cycle[31:0]; m_sh_cy = m_cycle[63:32]; m_sh_cy_v = 1'b1; end
                    12'hB80: begin r.rdata = m_sh_cy_v ? m_sh_cy : m_cycle[63:32]; m_sh_cy_v = 1'b0; end
                    12'hB02: begin r.rdata = m_instret[31:0]; m_sh_ir = m_instret[63:32]; m_sh_ir_v = 1'b1; end
                    12'hB82: begin r.rdata = m_sh_ir_v ? m_sh_ir : m_instret[63:32]; m_sh_ir_v = 1'b0; end
                    12'h320: r.rdata = {29'b0, m_ir, 1'b0, m_cy};
                    default: r.err = 1'b1;
                endcase
            end
            exp_q.push_back(r);
        end
        m_cycle   = nc;
        m_instret = ni;
        m_busy    = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ie);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h000, 32'h0, ie);
    endtask

    task automatic rd(input logic [11:0] addr);
        cyc(1'b1, 1'b0, addr, 32'h0, 1'b0);
        idle(1, 1'b0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        cyc(1'b1, 1'b1, addr, wd, 1'b0);
        idle(1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        csr_req    = 1'b0;
        csr_we     = 1'b0;
        csr_addr   = '0;
        csr_wdata  = '0;
        instret_en = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_cycle", cycle_count, 64'd0);
            check_eq("rst_instret", instret_count, 64'd0);
            check_eq("rst_ready", {63'b0, csr_ready}, 64'd0);
        end
    endtask

    task automatic check_ctr(input string tag);
        check_eq({tag, "_cycle"}, cycle_count, m_cycle);
        check_eq({tag, "_instret"}, instret_count, m_instret);
    endtask

    logic [63:0] snap_c, snap_i;
    logic [11:0] addr_tbl [0:5];

    initial begin
        addr_tbl[0] = 12'hB00; addr_tbl[1] = 12'hB80; addr_tbl[2] = 12'hB02;
        addr_tbl[3] = 12'hB82; addr_tbl[4] = 12'h320; addr_tbl[5] = 12'h7C0;
        rst = 1'b1; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0;
        csr_wdata = '0; instret_en = 1'b0;
        model_reset();
        do_reset(3);

        // Basic counting from reset release
        idle(6, 1'b0);
        idle(4, 1'b1);
        check_eq("count10_cycle", cycle_count, 64'd10);
        check_eq("count4_instret", instret_count, 64'd4);
        rd(12'hB00);
        rd(12'hB02);
        rd(12'hB82);

        // Low-half write followed by a carry into the high half
        wr(12'hB00, 32'hFFFF_FFFF);
        check_eq("carry_high", cycle_count, 64'h0000_0001_0000_0000);
        check_ctr("carry");

        // Writing a counter half invalidates its shadow
        rd(12'hB02);
        wr(12'hB82, 32'h0000_ABCD);
        rd(12'hB82);
        check_ctr("ir_hi_wr");

        // Inhibit both counters
        wr(12'h320, 32'h5);
        snap_c = m_cycle;
        snap_i = m_instret;
        idle(5, 1'b1);
        check_eq("frozen_cycle", cycle_count, snap_c);
        check_eq("frozen_instret", instret_count, snap_i);
        rd(12'h320);
        wr(12'h320, 32'h7);
        rd(12'h320);
        wr(12'h320, 32'h0);

        // High-half snapshot across a low-half wrap
        wr(12'hB80, 32'h1);
        cyc(1'b1, 1'b1, 12'hB00, 32'hFFFF_FFF0, 1'b0);
        rd(12'hB00);
        idle(20, 1'b0);
        rd(12'hB80);
        rd(12'hB80);
        check_eq("wrapped_high", {32'b0, cycle_count[63:32]}, 64'd2);

        // Unmapped accesses and a request held high through RESP
        rd(12'h7C0);
        wr(12'h7C0, 32'h1234_5678);
        check_ctr("unmapped");
        cyc(1'b1, 1'b0, 12'hB02, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 12'hB02, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 12'hB02, 32'h0, 1'b1);
        idle(1, 1'b0);

        // Randomised back-to-back mix
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                addr_tbl[$urandom_range(0, 5)], $urandom, 1'($urandom_range(0, 1)));
        end
        idle(1, 1'b0);
        check_ctr("random");
        wr(12'h320, 32'h0);

        // Reset asserted while a read response is pending
        wr(12'h320, 32'h5);
        cyc(1'b1, 1'b0, 12'hB00, 32'h0, 1'b1);
        do_reset(1);
        idle(1, 1'b0);
        check_eq("first_inc", cycle_count, 64'd1);
        rd(12'h320);
        idle(2, 1'b0);
        check_ctr("final");

        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
